cache_tick_tracker: RTL and testbench

CACHE_TICK_TRACKER -- requirements
Module: cache_tick_tracker

---
 rtl/cache_tick_tracker.sv | 143 ++++++++++++++
 tb/tb_cache_tick_tracker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tick_tracker.sv
// ============================================================================
//  Module   : cache_tick_tracker
//  Purpose  : Per-(set, way) recency timestamps for an LRU victim selector.
//             A global counter stamps each touched way; when the counter
//             would overflow, a pass halves every stored timestamp one set
//             per cycle so relative order is kept in a smaller range.
//  Macros   : CACHE_TICK_FWD_EN - forward same-cycle touch/invalidate onto
//                                 the tick outputs.
//             CACHE_E           - default ways per set (falls back to 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CACHE_E
`define CACHE_E 4
`endif

module cache_tick_tracker #(
  parameter int SET_COUNT  = 16,
  parameter int SET_SIZE   = `CACHE_E,
  parameter int TICK_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         touch_valid,
  input  logic [$clog2(SET_COUNT)-1:0] touch_set,
  input  logic [$clog2(SET_SIZE)-1:0]  touch_way,
  output logic                         touch_ready,
  input  logic                         inv_valid,
  input  logic [$clog2(SET_COUNT)-1:0] inv_set,
  input  logic [$clog2(SET_SIZE)-1:0]  inv_way,
  input  logic [$clog2(SET_COUNT)-1:0] lookup_set,
  output logic [31:0]                  tick [SET_SIZE],
  output logic                         busy
);

  localparam int SET_W = $clog2(SET_COUNT);
  localparam int WAY_W = $clog2(SET_SIZE);

  localparam logic [TICK_WIDTH-1:0] NOW_RESET = TICK_WIDTH'(1);
  // After a normalization pass every stored tick is below half-range,
  // so the counter restarts at half-range to stay strictly newest.
  localparam logic [TICK_WIDTH-1:0] NOW_AFTER_NORM = TICK_WIDTH'(1) << (TICK_WIDTH - 1);
  localparam logic [SET_W-1:0]      LAST_SET = SET_W'(SET_COUNT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    NORM = 1'b1
  } state_t;

  state_t                state;
  logic [TICK_WIDTH-1:0] mem [SET_COUNT][SET_SIZE];
  logic [TICK_WIDTH-1:0] now;
  logic [SET_W-1:0]      ptr;
  logic                  touch_acc;

  assign touch_acc = touch_valid && touch_ready;

  // Halve a timestamp; zero (invalid) stays zero, valid entries never
  // collapse to zero so they remain distinguishable from invalid ways.
  function automatic logic [TICK_WIDTH-1:0] halve(input logic [TICK_WIDTH-1:0] t);
    if (t == '0) begin
      return '0;
    end else if (t[TICK_WIDTH-1:1] == '0) begin
      return TICK_WIDTH'(1);
    end else begin
      return t >> 1;
    end
  endfunction

  // Control FSM, timestamp storage and global counter; invalidate is
  // applied last so it overrides both touch and halving of the same entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SET_COUNT; s++) begin
        for (int w = 0; w < SET_SIZE; w++) begin
          mem[s][w] <= '0;
        end
      end
      now         <= NOW_RESET;
      ptr         <= '0;
      state       <= IDLE;
      touch_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (touch_acc) begin
            mem[touch_set][touch_way] <= now;
            now                       <= now + TICK_WIDTH'(1);
            if (now == '1) begin
              state       <= NORM;
              ptr         <= '0;
              touch_ready <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        NORM: begin
          for (int w = 0; w < SET_SIZE; w++) begin
            mem[ptr][w] <= halve(mem[ptr][w]);
          end
          if (ptr == LAST_SET) begin
            ptr         <= '0;
            now         <= NOW_AFTER_NORM;
            state       <= IDLE;
            touch_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            ptr <= ptr + SET_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          touch_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
      if (inv_valid) begin
        mem[inv_set][inv_way] <= '0;
      end
    end
  end

  // Present the looked-up set's ticks, zero-extended to 32 bits.
  for (genvar w = 0; w < SET_SIZE; w++) begin : g_tick
    logic [TICK_WIDTH-1:0] val;
    always_comb begin
      val = mem[lookup_set][w];
`ifdef CACHE_TICK_FWD_EN
      if (inv_valid && inv_set == lookup_set && inv_way == WAY_W'(w)) begin
        val = '0;
      end else if (touch_acc && touch_set == lookup_set && touch_way == WAY_W'(w)) begin
        val = now;
      end
`endif
    end
    assign tick[w] = 32'(val);
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_tick_tracker.sv
// ============================================================================
//  Module   : tb_cache_tick_tracker
//  Purpose  : Directed self-checking bench for cache_tick_tracker. One large
//             instance (16 sets, 32-bit ticks) and one small instance
//             (4 sets, 4-bit ticks) that reaches normalization quickly.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_tick_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Large instance
  logic        big_resetn = 1'b0;
  logic        big_touch_valid = 1'b0;
  logic [3:0]  big_touch_set = '0;
  logic [1:0]  big_touch_way = '0;
  logic        big_touch_ready;
  logic        big_inv_valid = 1'b0;
  logic [3:0]  big_inv_set = '0;
  logic [1:0]  big_inv_way = '0;
  logic [3:0]  big_lookup_set = '0;
  logic [31:0] big_tick [4];
  logic        big_busy;

  // Small instance
  logic        sm_resetn = 1'b0;
  logic        sm_touch_valid = 1'b0;
  logic [1:0]  sm_touch_set = '0;
  logic [1:0]  sm_touch_way = '0;
  logic        sm_touch_ready;
  logic        sm_inv_valid = 1'b0;
  logic [1:0]  sm_inv_set = '0;
  logic [1:0]  sm_inv_way = '0;
  logic [1:0]  sm_lookup_set = '0;
  logic [31:0] sm_tick [4];
  logic        sm_busy;

  cache_tick_tracker #(.SET_COUNT(16), .SET_SIZE(4), .TICK_WIDTH(32)) u_big (
    .clk(clk), .resetn(big_resetn),
    .touch_valid(big_touch_valid), .touch_set(big_touch_set), .touch_way(big_touch_way),
    .touch_ready(big_touch_ready),
    .inv_valid(big_inv_valid), .inv_set(big_inv_set), .inv_way(big_inv_way),
    .lookup_set(big_lookup_set), .tick(big_tick), .busy(big_busy)
  );

  cache_tick_tracker #(.SET_COUNT(4), .SET_SIZE(4), .TICK_WIDTH(4)) u_sm (
    .clk(clk), .resetn(sm_resetn),
    .touch_valid(sm_touch_valid), .touch_set(sm_touch_set), .touch_way(sm_touch_way),
    .touch_ready(sm_touch_ready),
    .inv_valid(sm_inv_valid), .inv_set(sm_inv_set), .inv_way(sm_inv_way),
    .lookup_set(sm_lookup_set), .tick(sm_tick), .busy(sm_busy)
  );

  // Expected small-instance contents after the first normalization pass
  // (set 2 way 0 invalidated during its halving cycle).
  int sm_norm_exp [4][4] = '{'{1, 1, 1, 2}, '{2, 3, 3, 4}, '{0, 5, 5, 6}, '{6, 7, 7, 0}};

  task automatic big_touch(input logic [3:0] s, input logic [1:0] w);
    big_touch_valid = 1'b1; big_touch_set = s; big_touch_way = w;
    @(posedge clk); #1;
    big_touch_valid = 1'b0;
  endtask

  task automatic sm_touch(input logic [1:0] s, input logic [1:0] w);
    sm_touch_valid = 1'b1; sm_touch_set = s; sm_touch_way = w;
    @(posedge clk); #1;
    sm_touch_valid = 1'b0;
  endtask

  task automatic test_reset();
    big_lookup_set = 4'd3; sm_lookup_set = 2'd3;
    #1;
    for (int w = 0; w < 4; w++) begin
      vectors++;
      if (big_tick[w] !== 32'd0) begin
        $display("FAIL reset_tick[%0d]: got %0d expected 0", w, big_tick[w]); miscompares++;
      end
    end
    vectors++;
    if (big_touch_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b expected 1", big_touch_ready); miscompares++;
    end
    vectors++;
    if (big_busy !== 1'b0) begin
      $display("FAIL reset_busy: got %b expected 0", big_busy); miscompares++;
    end
    vectors++;
    if (sm_busy !== 1'b0 || sm_touch_ready !== 1'b1) begin
      $display("FAIL reset_sm_ctrl: got busy=%b ready=%b expected busy=0 ready=1", sm_busy, sm_touch_ready);
      miscompares++;
    end
  endtask

  task automatic test_touch_order();
    int exp_t [4] = '{2, 1, 0, 3};
    big_touch(4'd2, 2'd1);
    big_touch(4'd2, 2'd0);
    big_touch(4'd2, 2'd3);
    big_lookup_set = 4'd2;
    #1;
    for (int w = 0; w < 4; w++) begin
      vectors++;
      if (big_tick[w] !== 32'(exp_t[w])) begin
        $display("FAIL order_tick[%0d]: got %0d expected %0d", w, big_tick[w], exp_t[w]); miscompares++;
      end
    end
  endtask

  task automatic test_touch_inv_same();
    big_touch_valid = 1'b1; big_touch_set = 4'd5; big_touch_way = 2'd2;
    big_inv_valid = 1'b1; big_inv_set = 4'd5; big_inv_way = 2'd2;
    @(posedge clk); #1;
    big_touch_valid = 1'b0; big_inv_valid = 1'b0;
    big_lookup_set = 4'd5;
    #1;
    vectors++;
    if (big_tick[2] !== 32'd0) begin
      $display("FAIL collide_entry: got %0d expected 0", big_tick[2]); miscompares++;
    end
    // now went 4 -> 5 on the colliding touch
    big_touch(4'd5, 2'd1);
    #1;
    vectors++;
    if (big_tick[1] !== 32'd5) begin
      $display("FAIL collide_now: got %0d expected 5", big_tick[1]); miscompares++;
    end
  endtask

  task automatic test_invalidate();
    big_inv_valid = 1'b1; big_inv_set = 4'd2; big_inv_way = 2'd0;
    @(posedge clk); #1;
    big_inv_valid = 1'b0;
    big_lookup_set = 4'd2;
    #1;
    vectors++;
    if (big_tick[0] !== 32'd0 || big_tick[1] !== 32'd1 || big_tick[3] !== 32'd3) begin
      $display("FAIL inv_set2: got %0d,%0d,%0d expected 0,1,3", big_tick[0], big_tick[1], big_tick[3]);
      miscompares++;
    end
  endtask

  task automatic test_forward();
    // now is 6 here; three touches bring it to 9
    big_touch(4'd6, 2'd0);
    big_touch(4'd6, 2'd1);
    big_touch(4'd6, 2'd2);
    big_lookup_set = 4'd6;
    #1;
    vectors++;
    if (big_tick[0] !== 32'd6 || big_tick[1] !== 32'd7 || big_tick[2] !== 32'd8) begin
      $display("FAIL seq_set6: got %0d,%0d,%0d expected 6,7,8", big_tick[0], big_tick[1], big_tick[2]);
      miscompares++;
    end
    big_lookup_set = 4'd1;
    big_touch_valid = 1'b1; big_touch_set = 4'd1; big_touch_way = 2'd0;
    #1;
    vectors++;
`ifdef CACHE_TICK_FWD_EN
    if (big_tick[0] !== 32'd9) begin
      $display("FAIL fwd_same_cycle: got %0d expected 9", big_tick[0]); miscompares++;
    end
`else
    if (big_tick[0] !== 32'd0) begin
      $display("FAIL fwd_same_cycle: got %0d expected 0", big_tick[0]); miscompares++;
    end
`endif
    @(posedge clk); #1;
    big_touch_valid = 1'b0;
    #1;
    vectors++;
    if (big_tick[0] !== 32'd9) begin
      $display("FAIL fwd_next_cycle: got %0d expected 9", big_tick[0]); miscompares++;
    end
  endtask

  task automatic test_normalize();
    for (int i = 0; i < 15; i++) begin
      sm_touch(2'(i / 4), 2'(i % 4));
    end
    sm_lookup_set = 2'd3;
    #1;
    vectors++;
    if (sm_tick[2] !== 32'd15) begin
      $display("FAIL norm_pre_max: got %0d expected 15", sm_tick[2]); miscompares++;
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (sm_busy !== 1'b1 || sm_touch_ready !== 1'b0) begin
        $display("FAIL norm_busy_c%0d: got busy=%b ready=%b expected busy=1 ready=0", c, sm_busy, sm_touch_ready);
        miscompares++;
      end
      if (c == 2) begin
        sm_inv_valid = 1'b1; sm_inv_set = 2'd2; sm_inv_way = 2'd0;
      end
      @(posedge clk); #1;
      sm_inv_valid = 1'b0;
    end
    vectors++;
    if (sm_busy !== 1'b0 || sm_touch_ready !== 1'b1) begin
      $display("FAIL norm_end: got busy=%b ready=%b expected busy=0 ready=1", sm_busy, sm_touch_ready);
      miscompares++;
    end
    for (int s = 0; s < 4; s++) begin
      sm_lookup_set = 2'(s);
      #1;
      for (int w = 0; w < 4; w++) begin
        vectors++;
        if (sm_tick[w] !== 32'(sm_norm_exp[s][w])) begin
          $display("FAIL norm_halved[%0d][%0d]: got %0d expected %0d", s, w, sm_tick[w], sm_norm_exp[s][w]);
          miscompares++;
        end
      end
    end
    sm_touch(2'd0, 2'd0);
    sm_lookup_set = 2'd0;
    #1;
    vectors++;
    if (sm_tick[0] !== 32'd8) begin
      $display("FAIL norm_now: got %0d expected 8", sm_tick[0]); miscompares++;
    end
  endtask

  task automatic test_reset_mid_norm();
    // now is 9; seven touches write 9..15 and the last starts a pass
    for (int i = 0; i < 7; i++) begin
      sm_touch(2'd1, 2'd0);
    end
    vectors++;
    if (sm_busy !== 1'b1) begin
      $display("FAIL midnorm_entry: got busy=%b expected 1", sm_busy); miscompares++;
    end
    @(posedge clk); #2;
    sm_resetn = 1'b0;
    sm_lookup_set = 2'd3;
    #1;
    for (int w = 0; w < 4; w++) begin
      vectors++;
      if (sm_tick[w] !== 32'd0) begin
        $display("FAIL midnorm_tick[%0d]: got %0d expected 0", w, sm_tick[w]); miscompares++;
      end
    end
    vectors++;
    if (sm_busy !== 1'b0 || sm_touch_ready !== 1'b1) begin
      $display("FAIL midnorm_ctrl: got busy=%b ready=%b expected busy=0 ready=1", sm_busy, sm_touch_ready);
      miscompares++;
    end
    #3;
    sm_resetn = 1'b1;
    @(posedge clk); #1;
    sm_touch(2'd2, 2'd1);
    sm_lookup_set = 2'd2;
    #1;
    vectors++;
    if (sm_tick[1] !== 32'd1 || sm_busy !== 1'b0) begin
      $display("FAIL midnorm_now: got tick=%0d busy=%b expected tick=1 busy=0", sm_tick[1], sm_busy);
      miscompares++;
    end
  endtask

  initial begin
    #12;
    big_resetn = 1'b1;
    sm_resetn  = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_touch_order();
    test_touch_inv_same();
    test_invalidate();
    test_forward();
    test_normalize();
    test_reset_mid_norm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
